ppg_multich_controller: RTL and testbench

- Next-generation front-end controller for the PPG fingerclip chain.
- Time-multiplexes NUM_CH LEDs (generalises the fixed IR/RED pair) and samples the shared ADC once per LED slot.
- On Find_setting, auto-calibrates each channel: SAR search of DC_Comp, then PGA gain ramp.
- Sits between the ADC/analogue front-end model and downstream filtering; also supplies CLK_Filter.

---
 rtl/ppg_pkg.sv | 23 ++
 rtl/ppg_multich_controller_if.sv | 14 +
 rtl/ppg_slot_timer.sv | 34 +++
 rtl/ppg_multich_controller.sv | 171 +++++++++++++++++
 tb/tb_ppg_multich_controller.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared state encoding, default window constants and width helper
package ppg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAL_DC   = 2'd1,
    CAL_GAIN = 2'd2,
    RUN      = 2'd3
  } ppg_state_e;

  localparam int DEF_TARGET_LO = 32;
  localparam int DEF_TARGET_HI = 223;
  localparam int DEF_ADC_MID   = 128;

  // Never returns 0 so single-entry fields still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ppg_multich_controller_if.sv
// rtl/ppg_multich_controller_if.sv - per-channel sample output bus
interface ppg_multich_controller_if #(
  parameter int NUM_CH = 2,
  parameter int ADC_W  = 8
);
  localparam int CHW = ppg_pkg::clog2(NUM_CH);

  logic [NUM_CH*ADC_W-1:0] ch_value;
  logic                    value_valid;
  logic [CHW-1:0]          valid_ch;

  modport master (output ch_value, output value_valid, output valid_ch);
  modport slave  (input ch_value, input value_valid, input valid_ch);
endinterface

// File: rtl/ppg_slot_timer.sv
// rtl/ppg_slot_timer.sv - LED slot phase counter: settle, sample, dead cycle
module ppg_slot_timer
  import ppg_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic led_on,
  output logic sample_strobe,
  output logic slot_end
);
  localparam int PW = clog2(SETTLE_CYC + 2);
  localparam logic [PW-1:0] P_SAMPLE = PW'(SETTLE_CYC);
  localparam logic [PW-1:0] P_END    = PW'(SETTLE_CYC + 1);

  logic [PW-1:0] phase;

  // clear parks on the dead phase so the next cycle opens a fresh slot
  always_ff @(posedge clk) begin
    if (rst)
      phase <= '0;
    else if (clear)
      phase <= P_END;
    else if (en)
      phase <= (phase == P_END) ? '0 : phase + 1'b1;
  end

  assign led_on        = en && (phase <= P_SAMPLE);
  assign sample_strobe = en && (phase == P_SAMPLE);
  assign slot_end      = en && (phase == P_END);
endmodule

// File: rtl/ppg_multich_controller.sv
// rtl/ppg_multich_controller.sv - multi-LED PPG front-end sequencer with DC/gain auto-calibration
module ppg_multich_controller
  import ppg_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DCC_W      = 7,
  parameter int GAIN_W     = 4,
  parameter int DRIVE_W    = 4,
  parameter int SETTLE_CYC = 4,
  parameter int TARGET_LO  = DEF_TARGET_LO,
  parameter int TARGET_HI  = DEF_TARGET_HI,
  parameter int ADC_MID    = DEF_ADC_MID,
  parameter int FILT_DIV   = 8
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [ADC_W-1:0]          ADC,
  input  logic                      Find_setting,
  input  logic [NUM_CH*DRIVE_W-1:0] drive_cfg,
  output logic [NUM_CH-1:0]         LED_EN,
  output logic [DRIVE_W-1:0]        LED_DRIVE,
  output logic [DCC_W-1:0]          DC_Comp,
  output logic [GAIN_W-1:0]         PGA_Gain,
  output logic                      CLK_Filter,
  output logic                      cal_done,
  output logic [NUM_CH-1:0]         cal_fail,
  ppg_multich_controller_if.master  vbus
);
  localparam int CHW = clog2(NUM_CH);
  localparam int BW  = clog2(DCC_W);
  localparam int FW  = clog2(FILT_DIV);

  localparam logic [1:0] S_IDLE     = 2'(IDLE);
  localparam logic [1:0] S_CAL_DC   = 2'(CAL_DC);
  localparam logic [1:0] S_CAL_GAIN = 2'(CAL_GAIN);
  localparam logic [1:0] S_RUN      = 2'(RUN);

  localparam logic [GAIN_W-1:0] GMAX    = '1;
  localparam logic [CHW-1:0]    LAST_CH = CHW'(NUM_CH - 1);

  logic [1:0]        state;
  logic [CHW-1:0]    ch;
  logic [BW-1:0]     bit_idx;
  logic [DCC_W-1:0]  sar;
  logic [GAIN_W-1:0] gain_t;
  logic [DCC_W-1:0]  dcc_reg  [NUM_CH];
  logic [GAIN_W-1:0] gain_reg [NUM_CH];
  logic [FW-1:0]     filt_cnt;

  logic              led_on, sample_strobe, slot_end;
  logic [DCC_W-1:0]  bit_mask, sar_keep;
  logic              in_win;
  logic [GAIN_W-1:0] gain_store;

  ppg_slot_timer #(.SETTLE_CYC(SETTLE_CYC)) u_slot_timer (
    .clk           (CLK),
    .rst           (rst),
    .clear         (Find_setting),
    .en            (state != S_IDLE),
    .led_on        (led_on),
    .sample_strobe (sample_strobe),
    .slot_end      (slot_end)
  );

  assign bit_mask   = DCC_W'(1) << bit_idx;
  assign sar_keep   = (ADC >= ADC_W'(ADC_MID)) ? (sar | bit_mask) : sar;
  assign in_win     = (ADC >= ADC_W'(TARGET_LO)) && (ADC <= ADC_W'(TARGET_HI));
  assign gain_store = in_win ? GMAX : ((gain_t == '0) ? '0 : gain_t - 1'b1);
  assign LED_EN     = led_on ? (NUM_CH'(1) << ch) : '0;

  // Decisions land on the sample edge; the next slot's drive values load on the dead-cycle edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state            <= S_IDLE;
      ch               <= '0;
      bit_idx          <= '0;
      sar              <= '0;
      gain_t           <= '0;
      cal_done         <= 1'b0;
      cal_fail         <= '0;
      DC_Comp          <= '0;
      PGA_Gain         <= '0;
      LED_DRIVE        <= '0;
      vbus.ch_value    <= '0;
      vbus.value_valid <= 1'b0;
      vbus.valid_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dcc_reg[i]  <= '0;
        gain_reg[i] <= '0;
      end
    end else begin
      vbus.value_valid <= 1'b0;
      if (Find_setting) begin
        state    <= S_CAL_DC;
        ch       <= '0;
        bit_idx  <= BW'(DCC_W - 1);
        sar      <= '0;
        gain_t   <= '0;
        cal_done <= 1'b0;
        cal_fail <= '0;
      end else if (sample_strobe) begin
        case (state)
          S_CAL_DC: begin
            if (bit_idx == '0) begin
              dcc_reg[ch] <= sar_keep;
              gain_t      <= '0;
              state       <= S_CAL_GAIN;
            end else begin
              sar     <= sar_keep;
              bit_idx <= bit_idx - 1'b1;
            end
          end
          S_CAL_GAIN: begin
            if (in_win && gain_t != GMAX) begin
              gain_t <= gain_t + 1'b1;
            end else begin
              gain_reg[ch] <= gain_store;
              cal_fail[ch] <= !in_win && (gain_t == '0);
              if (ch == LAST_CH) begin
                ch       <= '0;
                state    <= S_RUN;
                cal_done <= 1'b1;
              end else begin
                ch      <= ch + 1'b1;
                bit_idx <= BW'(DCC_W - 1);
                sar     <= '0;
                state   <= S_CAL_DC;
              end
            end
          end
          S_RUN: begin
            vbus.ch_value[int'(ch)*ADC_W +: ADC_W] <= ADC;
            vbus.value_valid <= 1'b1;
            vbus.valid_ch    <= ch;
            ch               <= (ch == LAST_CH) ? '0 : ch + 1'b1;
          end
          default: ;
        endcase
      end else if (slot_end) begin
        LED_DRIVE <= drive_cfg[int'(ch)*DRIVE_W +: DRIVE_W];
        case (state)
          S_CAL_DC: begin
            DC_Comp  <= sar | bit_mask;
            PGA_Gain <= '0;
          end
          S_CAL_GAIN: begin
            DC_Comp  <= dcc_reg[ch];
            PGA_Gain <= gain_t;
          end
          default: begin
            DC_Comp  <= dcc_reg[ch];
            PGA_Gain <= gain_reg[ch];
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      filt_cnt   <= '0;
      CLK_Filter <= 1'b0;
    end else if (filt_cnt == FW'(FILT_DIV - 1)) begin
      filt_cnt   <= '0;
      CLK_Filter <= ~CLK_Filter;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ppg_multich_controller.sv
// tb/tb_ppg_multich_controller.sv - randomized self-checking bench for ppg_multich_controller
module tb_ppg_multich_controller;
  localparam int NUM_CH = 2;
  localparam int DCC_W  = 7;
  localparam int GMAX   = 15;
  localparam int LO     = 32;
  localparam int HI     = 223;
  localparam int MID    = 128;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  adc;
  logic        find;
  logic [7:0]  drive_cfg;
  logic [1:0]  LED_EN;
  logic [3:0]  LED_DRIVE;
  logic [6:0]  DC_Comp;
  logic [3:0]  PGA_Gain;
  logic        CLK_Filter;
  logic        cal_done;
  logic [1:0]  cal_fail;

  int         off [2];
  int         slope, lim;
  bit         rand_mode;
  logic [7:0] rand_val;
  int         raw;
  int         exp_dcc [2];
  int         exp_gain [2];
  int         drv [2];
  int         n_total, n_bad;

  ppg_multich_controller_if #(.NUM_CH(2), .ADC_W(8)) vbus ();

  ppg_multich_controller dut (
    .CLK          (CLK),
    .rst          (rst),
    .ADC          (adc),
    .Find_setting (find),
    .drive_cfg    (drive_cfg),
    .LED_EN       (LED_EN),
    .LED_DRIVE    (LED_DRIVE),
    .DC_Comp      (DC_Comp),
    .PGA_Gain     (PGA_Gain),
    .CLK_Filter   (CLK_Filter),
    .cal_done     (cal_done),
    .cal_fail     (cal_fail),
    .vbus         (vbus)
  );

  always #5 CLK = ~CLK;

  // Analogue front-end stand-in: falls with DC compensation, rails high at/above a gain limit.
  assign raw = off[LED_EN[1]] - slope * int'(DC_Comp);
  assign adc = rand_mode ? rand_val :
               (int'(PGA_Gain) >= lim) ? 8'd255 :
               (raw < 0) ? 8'd0 : (raw > 255) ? 8'd255 : 8'(raw);

  function automatic int model_adc(input int c, input int d, input int g);
    int v;
    if (g >= lim) return 255;
    v = off[c] - slope * d;
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  function automatic void ref_cal(input int c, output int d, output int g, output bit f, output int ns);
    int t, a;
    d = 0;
    for (int b = DCC_W - 1; b >= 0; b--) begin
      t = d | (1 << b);
      if (model_adc(c, t, 0) >= MID) d = t;
    end
    g = 0; f = 1'b0; ns = 0;
    for (int k = 0; k <= GMAX; k++) begin
      ns++;
      a = model_adc(c, d, g);
      if (a >= LO && a <= HI) begin
        if (g == GMAX) break;
        g++;
      end else begin
        if (g == 0) f = 1'b1;
        else g--;
        break;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_total++;
      if (LED_EN !== 0 || LED_DRIVE !== 0 || DC_Comp !== 0 || PGA_Gain !== 0 || CLK_Filter !== 0 ||
          cal_done !== 0 || cal_fail !== 0 || vbus.ch_value !== 0 || vbus.value_valid !== 0 ||
          vbus.valid_ch !== 0) begin
        n_bad++;
        $display("FAIL reset cyc=%0d led=%b drv=%h dcc=%h gain=%h cf=%b done=%b fail=%b val=%h vv=%b got nonzero, need all 0",
                 k, LED_EN, LED_DRIVE, DC_Comp, PGA_Gain, CLK_Filter, cal_done, cal_fail, vbus.ch_value, vbus.value_valid);
      end
      find = ~find;
    end
    rst  = 1'b0;
    find = 1'b0;
  endtask

  task automatic test_clk_filter();
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      n_total++;
      if (CLK_Filter !== 1'((k / 8) % 2)) begin
        n_bad++;
        $display("FAIL clk_filter k=%0d got=%b need=%0d", k, CLK_Filter, (k / 8) % 2);
      end
    end
  endtask

  task automatic run_cal(input int o0, input int o1, input int sl, input int lm);
    int rd [2];
    int rg [2];
    bit f;
    logic [1:0] rf;
    int slots, ns, idx;
    bit vv_seen;
    off[0] = o0; off[1] = o1; slope = sl; lim = lm; rand_mode = 1'b0;
    slots = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      ref_cal(c, rd[c], rg[c], f, ns);
      rf[c] = f;
      slots += DCC_W + ns;
    end
    @(negedge CLK); find = 1'b1;
    @(negedge CLK); find = 1'b0;
    n_total++;
    if (LED_EN !== 2'b00 || cal_done !== 1'b0 || cal_fail !== 2'b00) begin
      n_bad++;
      $display("FAIL cal_start led=%b done=%b fail=%b need 00/0/00", LED_EN, cal_done, cal_fail);
    end
    idx = 0; vv_seen = 1'b0;
    while (cal_done !== 1'b1 && idx < 2000) begin
      @(negedge CLK);
      idx++;
      if (vbus.value_valid === 1'b1) vv_seen = 1'b1;
      if (idx == 1) begin
        n_total++;
        if (LED_EN !== 2'b01 || DC_Comp !== 7'd64 || PGA_Gain !== 4'd0) begin
          n_bad++;
          $display("FAIL cal_first_slot led=%b dcc=%0d gain=%0d need 01/64/0", LED_EN, DC_Comp, PGA_Gain);
        end
      end
      if (idx == 1 + 6 * DCC_W) begin
        n_total++;
        if (LED_EN !== 2'b01 || DC_Comp !== 7'(rd[0]) || PGA_Gain !== 4'd0) begin
          n_bad++;
          $display("FAIL cal_gain_entry led=%b dcc=%0d gain=%0d need 01/%0d/0", LED_EN, DC_Comp, PGA_Gain, rd[0]);
        end
      end
    end
    n_total++;
    if (cal_done !== 1'b1 || idx != 6 * slots) begin
      n_bad++;
      $display("FAIL cal_length done=%b cycles=%0d need 1 at %0d", cal_done, idx, 6 * slots);
    end
    n_total++;
    if (cal_fail !== rf) begin
      n_bad++;
      $display("FAIL cal_fail got=%b need=%b", cal_fail, rf);
    end
    n_total++;
    if (vv_seen) begin
      n_bad++;
      $display("FAIL cal_value_valid got=1 during calibration need=0");
    end
    exp_dcc  = rd;
    exp_gain = rg;
  endtask

  task automatic test_run(input int n);
    int ch;
    logic [1:0] el;
    logic [7:0] smp;
    smp = 8'd0;
    rand_mode = 1'b1;
    rand_val  = 8'($urandom);
    for (int s = 0; s < n; s++) begin
      ch = s % 2;
      for (int ph = 0; ph < 6; ph++) begin
        @(negedge CLK);
        el = (ph <= 4) ? 2'(1 << ch) : 2'b00;
        n_total++;
        if (LED_EN !== el || vbus.value_valid !== 1'(ph == 5)) begin
          n_bad++;
          $display("FAIL run_seq slot=%0d ph=%0d led=%b vv=%b need %b/%0d", s, ph, LED_EN, vbus.value_valid, el, ph == 5);
        end
        if (ph == 0) begin
          n_total++;
          if (DC_Comp !== 7'(exp_dcc[ch]) || PGA_Gain !== 4'(exp_gain[ch]) || LED_DRIVE !== 4'(drv[ch])) begin
            n_bad++;
            $display("FAIL run_settings ch=%0d dcc=%0d gain=%0d drv=%0d need %0d/%0d/%0d",
                     ch, DC_Comp, PGA_Gain, LED_DRIVE, exp_dcc[ch], exp_gain[ch], drv[ch]);
          end
        end
        if (ph == 5) begin
          n_total++;
          if (vbus.valid_ch !== 1'(ch) || vbus.ch_value[ch*8 +: 8] !== smp || cal_done !== 1'b1) begin
            n_bad++;
            $display("FAIL run_value ch=%0d valid_ch=%0d val=%0d done=%b need %0d/%0d/1",
                     ch, vbus.valid_ch, vbus.ch_value[ch*8 +: 8], cal_done, ch, smp);
          end
        end
        if (ph == 4) smp = adc;
        else rand_val = 8'($urandom);
      end
    end
  endtask

  task automatic test_cal_dc();
    run_cal(255, 255, 2, 16);
    test_run(4);
    n_total++;
    if (DC_Comp !== 7'd63 || PGA_Gain !== 4'd15) begin
      n_bad++;
      $display("FAIL cal_dc_result dcc=%0d gain=%0d need 63/15", DC_Comp, PGA_Gain);
    end
  endtask

  task automatic test_cal_gain();
    run_cal(255, 255, 2, 5);
    test_run(2);
    n_total++;
    if (DC_Comp !== 7'd63 || PGA_Gain !== 4'd4 || cal_done !== 1'b1) begin
      n_bad++;
      $display("FAIL cal_gain_result dcc=%0d gain=%0d done=%b need 63/4/1", DC_Comp, PGA_Gain, cal_done);
    end
  endtask

  task automatic test_stuck_zero();
    run_cal(0, 0, 1, 16);
    test_run(2);
    n_total++;
    if (DC_Comp !== 7'd0 || PGA_Gain !== 4'd0 || cal_fail !== 2'b11 || cal_done !== 1'b1) begin
      n_bad++;
      $display("FAIL stuck_zero dcc=%0d gain=%0d fail=%b done=%b need 0/0/11/1", DC_Comp, PGA_Gain, cal_fail, cal_done);
    end
  endtask

  task automatic test_find_mid_run();
    repeat ($urandom_range(1, 11)) @(negedge CLK);
    run_cal($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 16));
    test_run(2);
  endtask

  task automatic test_random_cal();
    for (int it = 0; it < 4; it++) begin
      run_cal($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 16));
      test_run(2 + 2 * $urandom_range(0, 1));
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst = 1'b1; find = 1'b0; rand_mode = 1'b0; rand_val = 8'd0;
    off[0] = 0; off[1] = 0; slope = 2; lim = 16;
    drv[0] = $urandom_range(0, 15);
    drv[1] = $urandom_range(0, 15);
    drive_cfg = {4'(drv[1]), 4'(drv[0])};

    test_reset();
    test_clk_filter();
    test_cal_dc();
    test_cal_gain();
    test_stuck_zero();
    test_find_mid_run();
    test_random_cal();
    repeat ($urandom_range(1, 5)) @(negedge CLK);
    test_reset();
    test_clk_filter();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
